// File: rtl/tug_game_ctrl.sv
// Tug-of-war game sequencer, player vs computer: conditions the human key, draws
// computer presses from an LFSR, arbitrates moves and keeps score to a match win.
module tug_game_ctrl #(
  parameter int unsigned TICK_DIV    = 4096,
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned WIN_SCORE   = 7,
  parameter logic [9:0]  LFSR_SEED   = 10'h001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic [2:0] sw_diff,
  input  logic [9:1] led,
  output logic       L,
  output logic       R,
  output logic       wL,
  output logic       wR,
  output logic [2:0] score_l,
  output logic [2:0] score_r,
  output logic       game_over
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    WIN       = 3'(WIN_SCORE);

  typedef enum logic [1:0] {S_PLAY, S_HOLD, S_OVER} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [9:0]    lfsr_q, lfsr_d;
  logic          meta_q, meta_d, cur_q, cur_d, prev_q, prev_d;
  logic          l_q, l_d, r_q, r_d, wl_q, wl_d, wr_q, wr_d;
  logic [2:0]    score_l_q, score_l_d, score_r_q, score_r_d;
  logic          over_q, over_d;
  logic          hp, cp, tick, cool;

  // Only the two edge cells decide a round win.
  logic led_unused;
  assign led_unused = ^led[8:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_PLAY;
      hold_q    <= '0;
      tick_q    <= '0;
      lfsr_q    <= LFSR_SEED;
      meta_q    <= 1'b1;
      cur_q     <= 1'b1;
      prev_q    <= 1'b1;
      l_q       <= 1'b0;
      r_q       <= 1'b0;
      wl_q      <= 1'b0;
      wr_q      <= 1'b0;
      score_l_q <= '0;
      score_r_q <= '0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      tick_q    <= tick_d;
      lfsr_q    <= lfsr_d;
      meta_q    <= meta_d;
      cur_q     <= cur_d;
      prev_q    <= prev_d;
      l_q       <= l_d;
      r_q       <= r_d;
      wl_q      <= wl_d;
      wr_q      <= wr_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      over_q    <= over_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    l_d       = 1'b0;
    r_d       = 1'b0;
    wl_d      = 1'b0;
    wr_d      = 1'b0;
    meta_d    = key_n;
    cur_d     = meta_q;
    prev_d    = cur_q;
    lfsr_d    = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    tick      = (tick_q == TICK_LAST);
    tick_d    = tick ? '0 : tick_q + TW'(1);
    hp        = prev_q & ~cur_q;
    cp        = tick & (lfsr_q < {sw_diff, 7'b0});
    // A pulse is on the wire this cycle: led has not yet moved, so skip deciding.
    cool      = l_q | r_q;

    case (state_q)
      S_PLAY: begin
        if (!cool && hp && !cp) begin
          r_d = 1'b1;
          if (led[1]) begin
            wr_d      = 1'b1;
            score_r_d = score_r_q + 3'd1;
            hold_d    = HOLD_LOAD;
            state_d   = (score_r_d == WIN) ? S_OVER : S_HOLD;
          end
        end else if (!cool && cp && !hp) begin
          l_d = 1'b1;
          if (led[9]) begin
            wl_d      = 1'b1;
            score_l_d = score_l_q + 3'd1;
            hold_d    = HOLD_LOAD;
            state_d   = (score_l_d == WIN) ? S_OVER : S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == '0) state_d = S_PLAY;
        else              hold_d  = hold_q - HW'(1);
      end
      S_OVER:  state_d = S_OVER;
      default: state_d = S_PLAY;
    endcase

    over_d = (state_d == S_OVER);
  end

  assign L         = l_q;
  assign R         = r_q;
  assign wL        = wl_q;
  assign wR        = wr_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_tug_game_ctrl.sv
// Scoreboard bench for tug_game_ctrl: stimulus queues expected pulses,
// a negedge monitor pops and compares every L/R/wL/wR pulse.
module tb_tug_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_n;
  logic [2:0] sw_diff;
  logic [9:1] led;
  logic       L, R, wL, wR, game_over;
  logic [2:0] score_l, score_r;

  tug_game_ctrl #(
    .TICK_DIV(4), .HOLD_CYCLES(4), .WIN_SCORE(2), .LFSR_SEED(10'h001)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sw_diff(sw_diff), .led(led),
    .L(L), .R(R), .wL(wL), .wR(wR),
    .score_l(score_l), .score_r(score_r), .game_over(game_over)
  );

  always #5 clk = ~clk;

  localparam logic [9:1] LED_MID   = 9'b000010000;
  localparam logic [9:1] LED_RIGHT = 9'b000000001;
  localparam logic [9:1] LED_LEFT  = 9'b100000000;

  typedef struct {
    int         cyc;
    logic       l, r, wl, wr;
    logic [2:0] sl, sr;
    logic       go;
  } exp_t;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_pulse = 0;
  int         cyc;
  logic [9:0] m_lfsr;

  // Reference x^10+x^7+1 sequence and cycle index since the last reset edge.
  function automatic logic [9:0] lstep(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      cyc    <= 0;
      m_lfsr <= 10'h001;
    end else begin
      cyc    <= cyc + 1;
      m_lfsr <= lstep(m_lfsr);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!reset && (L | R | wL | wR)) begin
      exp_t e;
      n_pulse++;
      if (q.size() == 0) begin
        check("unexpected_pulse", int'({L, R, wL, wR}), 0);
      end else begin
        e = q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_flags", int'({L, R, wL, wR}), int'({e.l, e.r, e.wl, e.wr}));
        check("pulse_score_l", int'(score_l), int'(e.sl));
        check("pulse_score_r", int'(score_r), int'(e.sr));
        check("pulse_game_over", int'(game_over), int'(e.go));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pulses"}, int'({L, R, wL, wR}), 0);
    check({tag, "_score_l"}, int'(score_l), 0);
    check({tag, "_score_r"}, int'(score_r), 0);
    check({tag, "_game_over"}, int'(game_over), 0);
  endtask

  task automatic window(input int n, input int exp_cnt, input string name);
    int p;
    p = n_pulse;
    step(n);
    check(name, n_pulse - p, exp_cnt);
  endtask

  // Press the key now (cycle j); R is expected at cycle j+3.
  task automatic human(input int hold, input logic wr, input logic [2:0] sl,
                       input logic [2:0] sr, input logic go);
    q.push_back('{cyc + 3, 1'b0, 1'b1, 1'b0, wr, sl, sr, go});
    key_n = 1'b0;
    step(hold);
    key_n = 1'b1;
  endtask

  // Find a future tick cycle k (k%4==3) whose LFSR value lies in [lo,hi).
  task automatic find_tick(input int lo, input int hi, output int k, output logic [9:0] v);
    bit found;
    found = 1'b0;
    v = m_lfsr;
    k = cyc;
    for (int d = 1; d < 400 && !found; d++) begin
      v = lstep(v);
      if (d >= 3 && ((cyc + d) % 4) == 3 && int'(v) >= lo && int'(v) < hi) begin
        k = cyc + d;
        found = 1'b1;
      end
    end
    if (!found) begin
      $display("FAIL find_tick: no tick cycle with lfsr in [%0d,%0d)", lo, hi);
      $fatal(1);
    end
  endtask

  // Raise sw_diff for cycle k only.
  task automatic cpu_at(input int k, input logic [2:0] sw);
    step(k - cyc);
    sw_diff = sw;
    step(1);
    sw_diff = 3'd0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         k, p;
    logic [9:0] v;
    key_n   = 1'b1;
    sw_diff = 3'd0;
    led     = LED_MID;
    do_reset();
    check_idle("reset");

    // Computer disabled, key released: nothing moves.
    window(200, 0, "idle_no_pulse");

    // Held key: a single R three cycles after the fall, no round win.
    p = n_pulse;
    human(20, 1'b0, 3'd0, 3'd0, 1'b0);
    step(5);
    check("held_single_r", n_pulse - p, 1);

    // Human win at the right edge, then a press landing in HOLD is dropped.
    led = LED_RIGHT;
    human(1, 1'b1, 3'd0, 3'd1, 1'b0);
    step(3);
    key_n = 1'b0;
    step(1);
    key_n = 1'b1;
    window(12, 0, "hold_ignores_press");
    led = LED_MID;
    human(1, 1'b0, 3'd0, 3'd1, 1'b0);
    step(6);

    // Computer press just under the threshold yields L.
    find_tick(0, 896, k, v);
    q.push_back('{k + 1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0});
    cpu_at(k, 3'(int'(v) / 128 + 1));
    step(6);

    // LFSR equal to or above the threshold: no press.
    find_tick(128, 1024, k, v);
    p = n_pulse;
    cpu_at(k, 3'(int'(v) / 128));
    step(6);
    check("threshold_boundary_no_l", n_pulse - p, 0);

    // Human and computer press in the same cycle cancel.
    find_tick(0, 896, k, v);
    p = n_pulse;
    step(k - 2 - cyc);
    key_n = 1'b0;
    step(2);
    sw_diff = 3'd7;
    step(1);
    sw_diff = 3'd0;
    key_n   = 1'b1;
    step(8);
    check("simultaneous_cancel", n_pulse - p, 0);

    // Computer win at the left edge.
    led = LED_LEFT;
    find_tick(0, 896, k, v);
    q.push_back('{k + 1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 3'd1, 1'b0});
    cpu_at(k, 3'd7);
    step(10);
    led = LED_MID;

    // Two human wins end the match; OVER ignores everything until reset.
    do_reset();
    check_idle("reset2");
    led = LED_RIGHT;
    human(1, 1'b1, 3'd0, 3'd1, 1'b0);
    step(10);
    human(1, 1'b1, 3'd0, 3'd2, 1'b1);
    step(5);
    check("over_game_over", int'(game_over), 1);
    check("over_score_r", int'(score_r), 2);
    p = n_pulse;
    key_n   = 1'b0;
    sw_diff = 3'd7;
    step(20);
    key_n = 1'b1;
    step(20);
    sw_diff = 3'd0;
    step(5);
    check("over_no_pulse", n_pulse - p, 0);
    check("over_scores_frozen", int'(score_r), 2);
    do_reset();
    check_idle("reset_after_over");

    // Reset during HOLD returns to PLAY with scores cleared.
    human(1, 1'b1, 3'd0, 3'd1, 1'b0);
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_idle("reset_in_hold");
    led = LED_MID;
    human(1, 1'b0, 3'd0, 3'd0, 1'b0);
    step(6);

    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tug_game_ctrl.md
Name: tug_game_ctrl

Overview:
- Game sequencer for the 9-LED tug-of-war playfield in player-vs-computer mode.
- Conditions the human key into single press pulses and generates computer presses from an LFSR gated by a difficulty setting.
- Arbitrates simultaneous presses, issues one-cycle L/R move pulses and wL/wR round-win pulses to the light chain, and keeps per-side scores up to a match win.

Parameters:
- TICK_DIV, 4096: clock cycles between computer press opportunities (must be ≥2).
- HOLD_CYCLES, 25000000: cycles all presses are frozen after a round win (must be ≥1).
- WIN_SCORE, 7: round wins that end the match (1..7).
- LFSR_SEED, 10'h001: LFSR reset value (nonzero).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- key_n  input  1  raw human key, active-low, asynchronous to clk
- sw_diff  input  3  computer difficulty, 0 = computer never presses, 7 = hardest
- led  input  9 [9:1]  current playfield state; led[1] is the right edge, led[9] the left edge
- L  output  1  one-cycle pulse: move light left (computer)
- R  output  1  one-cycle pulse: move light right (human)
- wL  output  1  one-cycle pulse: left side (computer) won the round
- wR  output  1  one-cycle pulse: right side (human) won the round
- score_l  output  3  computer round wins
- score_r  output  3  human round wins
- game_over  output  1  high while the match is finished

Behaviour:
- Reset (synchronous, active-high; clk and reset as named above):
  - all outputs 0, state PLAY, LFSR = LFSR_SEED, tick counter 0, sync flops 1 (key released).
  - Reset mid-HOLD or in OVER returns to PLAY with scores 0.
- Human press path:
  - key_n passes through a 2-flop synchronizer.
  - hp = sync_prev & ~sync_cur, i.e. one cycle per 1->0 transition.
  - Holding the key gives a single hp.
- Computer press path:
  - 10-bit Fibonacci LFSR, x^10+x^7+1, shifts every cycle and never reaches 0.
  - The tick counter counts 0..TICK_DIV-1 and wraps; tick = 1 on the count==TICK_DIV-1 cycle.
  - cp = tick & (lfsr < {sw_diff, 7'b0}). Thresholds are 0, 128, ..., 896.
- Arbitration, PLAY state only:
  - hp & cp: cancel, no pulse.
  - hp only: R = 1 next cycle.
  - cp only: L = 1 next cycle.
- Cooldown:
  - The cycle after any L/R pulse, hp and cp are discarded.
  - This gives the light chain one cycle for led to settle before the next decision.
- Win detection, registered with the pulse:
  - L issued while sampled led[9] = 1: wL = 1 in the same cycle as L; score_l += 1.
  - R issued while sampled led[1] = 1: wR = 1 in the same cycle as R; score_r += 1.
- State machine:
  - PLAY: on a win, go to HOLD with the hold counter loaded to HOLD_CYCLES-1. If the incremented score == WIN_SCORE, go to OVER instead.
  - HOLD: no L/R/wL/wR. hp and cp are discarded. The counter decrements; at 0, go to PLAY.
  - OVER: game_over = 1. No L/R/wL/wR. Scores frozen. Exit only on reset.
- Scores:
  - 3-bit, never exceed WIN_SCORE; no wrap.
- Invariants:
  - L and R are never high together.
  - wL implies L; wR implies R.
  - wL and wR are never high together.
  - No two L/R pulses occur in consecutive cycles.
- The LFSR keeps running in HOLD and OVER.

Test Plan (overrides TICK_DIV=4, HOLD_CYCLES=4, WIN_SCORE=2):
- Reset → all outputs 0. With sw_diff=0, run 200 cycles with key released → no L/R ever.
- key_n held low 20 cycles with led=9'b000010000 → exactly one R pulse, 3 cycles after the falling edge (2 sync + 1 register); no wR.
- led=9'b000000001, single human press → R and wR high in the same cycle; score_r=1. For the next 4 cycles, presses are ignored (no R). Then PLAY resumes.
- sw_diff=7; force the LFSR below 896 at a tick while the human press lands on the same cycle → no L and no R.
- Two right-edge human wins → score_r=2, game_over=1. Further presses and ticks produce no pulses. Reset → score_r=0, game_over=0.
- Assert reset during HOLD → next cycle state PLAY, scores 0, wL=wR=L=R=0.
